pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage 19-bit-instruction MIPS core.
- Decides each cycle which pipeline registers advance, hold or receive bubbles. Covers three cases:
  - load-use hazards, which forwarding cannot cover;
  - taken-branch flushes;
  - data-memory wait states.
- Sits beside the forwarding unit and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables and clears.
- Also keeps saturating stall and flush counters for performance debug.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.
- FLUSH_CYC, 1, number of extra squash cycles after a taken branch (instruction memory latency). Legal range 1..3.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_id_instruction  in  19  instruction in IF/ID.
- id_ex_instruction  in  19  instruction in ID/EX.
- if_id_valid  in  1  IF/ID holds a real instruction.
- id_ex_valid  in  1  ID/EX holds a real instruction.
- branch_taken  in  1  EX resolved a taken branch or jump. Only meaningful when id_ex_valid=1.
- mem_req  in  1  EX/MEM holds a valid lw or sw.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID to a bubble (valid=0).
- id_ex_write  out  1  ID/EX load enable.
- id_ex_bubble  out  1  load a bubble into ID/EX instead of the decoded instruction.
- ex_mem_write  out  1  EX/MEM load enable.
- mem_wb_bubble  out  1  load a bubble into MEM/WB.
- state  out  2  FSM state, for debug.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0.
- flush_cnt  out  CNT_W  saturating count of taken-branch flush events.

Behaviour:
- Decode fields:
  - opcode = [18:14], dst = [13:11], srcA = [10:8], srcB = [7:5].
  - ALU: [18]=0. Immediate: [17]=1.
  - lw = 10000, sw = 10001.
  - sw reads srcA (base) and dst (store data).
  - ALU reads srcA, and reads srcB only if non-immediate.
- Load-use hazard (lu_haz), asserted only when all of the following hold:
  - id_ex_valid and if_id_valid are both 1;
  - ID/EX holds a lw with dst != 0;
  - dst equals a register read by the IF/ID instruction.
- States:
  - RUN = 0, MEM_WAIT = 1, LU_STALL = 2, FLUSH = 3.
  - Reset forces RUN and clears both counters.
- Output reset values:
  - all write enables = 1;
  - if_id_flush, id_ex_bubble, mem_wb_bubble = 0.
  - These are the per-cycle defaults in RUN when there is no event.
- Priority each cycle: memory wait > branch > load-use.
- Memory wait (mem_req=1 and mem_ready=0), in any state:
  - pc_write = if_id_write = id_ex_write = ex_mem_write = 0;
  - mem_wb_bubble = 1;
  - next state MEM_WAIT.
  - The FLUSH remaining-cycle counter and any pending branch decision are held, not lost.
- MEM_WAIT: on the first cycle with mem_ready=1:
  - release everything (defaults);
  - next state RUN, or resume the held FLUSH if one was active.
- Branch (branch_taken=1 and id_ex_valid=1, no memory wait):
  - if_id_flush = 1 and id_ex_bubble = 1; PC loads the target (pc_write=1);
  - flush_cnt increments;
  - next state FLUSH with the remaining counter = FLUSH_CYC.
  - A branch overrides a coincident lu_haz; the stall is dropped.
- FLUSH:
  - each cycle if_id_flush = 1 and the counter decrements;
  - lu_haz is ignored;
  - return to RUN when the counter reaches 0.
- Load-use (lu_haz in RUN, no higher-priority event):
  - pc_write = if_id_write = 0 and id_ex_bubble = 1 for exactly one cycle;
  - next state LU_STALL.
- LU_STALL:
  - defaults apply; lu_haz is not re-evaluated (ID/EX is now a bubble);
  - next state RUN.
  - After this single bubble, the lw value reaches the consumer through MEM/WB forwarding.
- Counters:
  - stall_cnt increments in every cycle with pc_write=0.
  - Both counters saturate at all-ones.
- Reset asserted mid-stall or mid-flush: immediate return to RUN with default outputs; no pending event survives.
- All outputs are combinational from the state, the registered counters and the current inputs.
- No combinational path runs from mem_ready to state other than via the next-state logic.

Test Plan:
- Load-use: ID/EX = lw r3 (opcode 10000, dst=3), IF/ID = add with srcA=3 -> for 1 cycle pc_write=0, if_id_write=0, id_ex_bubble=1, state 0->2->0; stall_cnt=1.
- No false stall: ID/EX = lw dst=0, IF/ID reads r0 -> no stall. IF/ID = addi with srcB=3 after lw r3 -> no stall. IF/ID = sw with dst=3 after lw r3 -> stall.
- Branch with FLUSH_CYC=2: branch_taken=1 -> if_id_flush=1 and id_ex_bubble=1 in cycle 0; if_id_flush=1 for 2 more cycles; flush_cnt=1; a coincident lu_haz produces no stall.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles -> pc_write, if_id_write, id_ex_write, ex_mem_write = 0 and mem_wb_bubble=1 for 3 cycles; RUN on the 4th; stall_cnt=3.
- Memory wait during FLUSH (FLUSH_CYC=2, wait after the 1st squash cycle) -> FLUSH resumes with 1 remaining squash cycle after mem_ready.
- Drop rst_n during LU_STALL and during MEM_WAIT -> state=0 immediately (asynchronously), defaults on outputs, counters=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: stage status in, register enables/clears out.
// master = pipeline datapath, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
   logic [18:0] if_id_instruction;
   logic [18:0] id_ex_instruction;
   logic        if_id_valid;
   logic        id_ex_valid;
   logic        branch_taken;
   logic        mem_req;
   logic        mem_ready;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_flush;
   logic        id_ex_write;
   logic        id_ex_bubble;
   logic        ex_mem_write;
   logic        mem_wb_bubble;

   modport master (
      output if_id_instruction, id_ex_instruction, if_id_valid, id_ex_valid,
             branch_taken, mem_req, mem_ready,
      input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
             ex_mem_write, mem_wb_bubble
   );

   modport slave (
      input  if_id_instruction, id_ex_instruction, if_id_valid, id_ex_valid,
             branch_taken, mem_req, mem_ready,
      output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
             ex_mem_write, mem_wb_bubble
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and data-memory wait
// states for the 5-stage 19-bit MIPS core, plus saturating stall/flush debug counters.
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned FLUSH_CYC = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   pipe_hazard_ctrl_if.slave   pipe,
   output logic [1:0]          state,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    flush_cnt
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StLuStall = 2'd2,
      StFlush   = 2'd3
   } state_e;

   localparam logic [1:0] FlushInit = 2'(FLUSH_CYC);

   state_e           state_q, state_d;
   logic [1:0]       rem_q, rem_d;
   logic             resume_q, resume_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic [4:0] ex_op, if_op;
   logic [2:0] ex_dst, if_dst, if_src_a, if_src_b;
   logic       ex_lw, if_alu, if_imm, if_sw;
   logic       rd_a, rd_b, rd_d;
   logic       lu_haz, mem_wait, br;

   assign ex_op    = pipe.id_ex_instruction[18:14];
   assign ex_dst   = pipe.id_ex_instruction[13:11];
   assign if_op    = pipe.if_id_instruction[18:14];
   assign if_dst   = pipe.if_id_instruction[13:11];
   assign if_src_a = pipe.if_id_instruction[10:8];
   assign if_src_b = pipe.if_id_instruction[7:5];

   assign ex_lw  = (ex_op == 5'b10000);
   assign if_alu = ~if_op[4];
   assign if_imm = if_op[3];
   assign if_sw  = (if_op == 5'b10001);

   // Registers actually read by the IF/ID instruction; sw reads dst as store data.
   assign rd_a = if_alu | if_sw;
   assign rd_b = if_alu & ~if_imm;
   assign rd_d = if_sw;

   assign lu_haz = pipe.id_ex_valid & pipe.if_id_valid & ex_lw & (ex_dst != 3'd0) &
                   ((rd_a & (ex_dst == if_src_a)) |
                    (rd_b & (ex_dst == if_src_b)) |
                    (rd_d & (ex_dst == if_dst)));

   assign mem_wait = pipe.mem_req & ~pipe.mem_ready;
   assign br       = pipe.branch_taken & pipe.id_ex_valid;

   // State register and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         rem_q       <= 2'd0;
         resume_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         resume_q <= resume_d;
         if (!pipe.pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (br && !mem_wait && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      resume_d = resume_q;
      if (mem_wait) begin
         // Park an in-progress flush; rem_q is left untouched so it resumes where it stopped.
         state_d = StMemWait;
         if (state_q == StFlush) begin
            resume_d = 1'b1;
         end else if (state_q != StMemWait) begin
            resume_d = 1'b0;
         end
      end else if (br) begin
         state_d  = StFlush;
         rem_d    = FlushInit;
         resume_d = 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (lu_haz) state_d = StLuStall;
            end
            StLuStall: state_d = StRun;
            StMemWait: begin
               state_d  = resume_q ? StFlush : StRun;
               resume_d = 1'b0;
            end
            StFlush: begin
               rem_d = rem_q - 2'd1;
               if (rem_q <= 2'd1) state_d = StRun;
            end
         endcase
      end
   end

   // Output logic
   always_comb begin
      pipe.pc_write      = 1'b1;
      pipe.if_id_write   = 1'b1;
      pipe.if_id_flush   = 1'b0;
      pipe.id_ex_write   = 1'b1;
      pipe.id_ex_bubble  = 1'b0;
      pipe.ex_mem_write  = 1'b1;
      pipe.mem_wb_bubble = 1'b0;
      if (!rst_n) begin
         // Held inputs must not leak an event out while reset is asserted.
      end else if (mem_wait) begin
         pipe.pc_write      = 1'b0;
         pipe.if_id_write   = 1'b0;
         pipe.id_ex_write   = 1'b0;
         pipe.ex_mem_write  = 1'b0;
         pipe.mem_wb_bubble = 1'b1;
      end else if (br) begin
         pipe.if_id_flush  = 1'b1;
         pipe.id_ex_bubble = 1'b1;
      end else begin
         unique case (state_q)
            StRun: begin
               if (lu_haz) begin
                  pipe.pc_write     = 1'b0;
                  pipe.if_id_write  = 1'b0;
                  pipe.id_ex_bubble = 1'b1;
               end
            end
            StFlush: pipe.if_id_flush = 1'b1;
            StLuStall, StMemWait: ;
         endcase
      end
   end

   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected controls and counters are queued per step
// and checked with immediate assertions half a cycle later.
module tb_pipe_hazard_ctrl;

   localparam int unsigned CntW = 4;

   // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write,
   //  mem_wb_bubble, state[1:0]}
   localparam logic [8:0] Def0 = 9'b110101000;
   localparam logic [8:0] Def1 = 9'b110101001;
   localparam logic [8:0] Def2 = 9'b110101010;
   localparam logic [8:0] Lu   = 9'b000111000;
   localparam logic [8:0] Br   = 9'b111111000;
   localparam logic [8:0] Fl   = 9'b111101011;
   localparam logic [8:0] Mw0  = 9'b000000100;
   localparam logic [8:0] Mw1  = 9'b000000101;
   localparam logic [8:0] Mw3  = 9'b000000111;

   typedef struct packed {
      logic [8:0]      ctl;
      logic [CntW-1:0] sc;
      logic [CntW-1:0] fc;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic [1:0]      state;
   logic [CntW-1:0] stall_cnt;
   logic [CntW-1:0] flush_cnt;

   pipe_hazard_ctrl_if ifc ();

   pipe_hazard_ctrl #(
      .CNT_W     (CntW),
      .FLUSH_CYC (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pipe      (ifc),
      .state     (state),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t            sb[$];
   int              n_assert = 0;
   int              n_fail   = 0;
   logic [CntW-1:0] exp_stall = '0;
   logic [CntW-1:0] exp_flush = '0;

   logic [18:0] lw3, lw0, add_a3, add_r0, addi_b3, sw_d3, nop;

   function automatic logic [18:0] mk(input logic [4:0] op, input logic [2:0] d,
                                      input logic [2:0] a, input logic [2:0] b);
      return {op, d, a, b, 5'b00000};
   endfunction

   task automatic sb_check(input string tag);
      exp_t e;
      logic [8:0] obs;
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL %s scoreboard empty: observed none, required one entry", tag);
      end else begin
         e   = sb.pop_front();
         obs = {ifc.pc_write, ifc.if_id_write, ifc.if_id_flush, ifc.id_ex_write,
                ifc.id_ex_bubble, ifc.ex_mem_write, ifc.mem_wb_bubble, state};
         n_assert++;
         assert (obs === e.ctl) else begin
            n_fail++;
            $error("FAIL %s ctl observed=%b required=%b", tag, obs, e.ctl);
         end
         n_assert++;
         assert (stall_cnt === e.sc) else begin
            n_fail++;
            $error("FAIL %s stall_cnt observed=%0d required=%0d", tag, stall_cnt, e.sc);
         end
         n_assert++;
         assert (flush_cnt === e.fc) else begin
            n_fail++;
            $error("FAIL %s flush_cnt observed=%0d required=%0d", tag, flush_cnt, e.fc);
         end
      end
   endtask

   task automatic drive(input logic [18:0] ifi, input logic [18:0] idi, input logic ifv,
                        input logic idv, input logic br, input logic mrq, input logic mrd);
      ifc.if_id_instruction = ifi;
      ifc.id_ex_instruction = idi;
      ifc.if_id_valid       = ifv;
      ifc.id_ex_valid       = idv;
      ifc.branch_taken      = br;
      ifc.mem_req           = mrq;
      ifc.mem_ready         = mrd;
   endtask

   // One clock cycle: drive, queue the expectation, check at negedge, advance.
   task automatic step(input string tag, input logic [18:0] ifi, input logic [18:0] idi,
                       input logic ifv, input logic idv, input logic br, input logic mrq,
                       input logic mrd, input logic [8:0] ctl);
      exp_t e;
      drive(ifi, idi, ifv, idv, br, mrq, mrd);
      e.ctl = ctl;
      e.sc  = exp_stall;
      e.fc  = exp_flush;
      sb.push_back(e);
      if (!ctl[8] && exp_stall != '1) exp_stall = exp_stall + 1'b1;
      if (ctl[6] && ctl[4] && exp_flush != '1) exp_flush = exp_flush + 1'b1;
      @(negedge clk);
      sb_check(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step(input string tag, input logic [8:0] ctl);
      step(tag, nop, nop, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ctl);
   endtask

   // Assert reset between edges and check the asynchronous return to defaults.
   task automatic reset_mid(input string tag);
      exp_t e;
      rst_n = 1'b0;
      #1;
      e.ctl = Def0;
      e.sc  = '0;
      e.fc  = '0;
      sb.push_back(e);
      sb_check(tag);
      exp_stall = '0;
      exp_flush = '0;
      @(negedge clk);
      drive(nop, nop, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      lw3     = mk(5'b10000, 3'd3, 3'd1, 3'd0);
      lw0     = mk(5'b10000, 3'd0, 3'd1, 3'd0);
      add_a3  = mk(5'b00000, 3'd4, 3'd3, 3'd2);
      add_r0  = mk(5'b00000, 3'd4, 3'd0, 3'd0);
      addi_b3 = mk(5'b01000, 3'd4, 3'd1, 3'd3);
      sw_d3   = mk(5'b10001, 3'd3, 3'd2, 3'd1);
      nop     = '0;

      rst_n = 1'b0;
      drive(nop, nop, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #3;
      begin
         exp_t e;
         e.ctl = Def0;
         e.sc  = '0;
         e.fc  = '0;
         sb.push_back(e);
         sb_check("reset");
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Load-use stall, then LU_STALL ignores the still-present hazard
      step("lu_haz",   add_a3, lw3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, Lu);
      step("lu_stall", add_a3, lw3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, Def2);
      idle_step("lu_back", Def0);

      // No false stalls
      step("lw_r0",   add_r0,  lw0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, Def0);
      step("addi_b3", addi_b3, lw3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, Def0);
      step("ifid_inv", add_a3, lw3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, Def0);
      step("idex_inv", add_a3, lw3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, Def0);
      step("sw_d3",   sw_d3,   lw3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, Lu);
      idle_step("sw_stall", Def2);
      idle_step("sw_back",  Def0);

      // Taken branch with coincident load-use: flush wins, FLUSH lasts 2 cycles
      step("branch", add_a3, lw3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, Br);
      step("flush1", add_a3, lw3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, Fl);
      step("flush2", add_a3, lw3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, Fl);
      idle_step("flush_done", Def0);
      step("br_invalid", nop, nop, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, Def0);

      // Three memory wait cycles, release on the fourth
      step("mw1",    nop, nop, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, Mw0);
      step("mw2",    nop, nop, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, Mw1);
      step("mw3",    nop, nop, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, Mw1);
      step("mw_rel", nop, nop, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, Def1);
      idle_step("mw_run", Def0);

      // Memory wait after the first squash cycle: one squash cycle remains afterwards
      step("fb_branch", nop, nop, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, Br);
      idle_step("fb_flush1", Fl);
      step("fb_wait", nop, nop, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, Mw3);
      step("fb_rel",  nop, nop, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, Def1);
      idle_step("fb_resume", Fl);
      idle_step("fb_done",   Def0);

      // Saturate stall_cnt
      for (int i = 0; i < 12; i++) begin
         step("sat_mw", nop, nop, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (i == 0) ? Mw0 : Mw1);
      end
      step("sat_rel", nop, nop, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, Def1);
      idle_step("stall_sat", Def0);

      // Saturate flush_cnt
      for (int i = 0; i < 14; i++) begin
         step("sat_br", nop, nop, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, Br);
         idle_step("sat_fl1", Fl);
         idle_step("sat_fl2", Fl);
      end
      idle_step("flush_sat", Def0);

      // Reset during LU_STALL (hazard inputs still driven)
      step("pre_rst_lu", add_a3, lw3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, Lu);
      reset_mid("rst_in_lu");
      idle_step("post_rst_lu", Def0);

      // Reset during MEM_WAIT (wait inputs still driven)
      step("pre_rst_mw1", nop, nop, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, Mw0);
      step("pre_rst_mw2", nop, nop, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, Mw1);
      ifc.mem_req   = 1'b1;
      ifc.mem_ready = 1'b0;
      reset_mid("rst_in_mw");
      idle_step("post_rst_mw", Def0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
